// File: rtl/conv_pkg.sv
// Shared types and helpers for the FFT-convolution AFU.
//   bank_state_e : life cycle of one ping-pong bank
//   quant()      : narrows one signed component (truncate, or round-half-up
//                  then saturate) and reports whether it saturated.
package conv_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Internal working width for quant(); callers pass components
    // sign-extended to QW bits and take the low result bits they need.
    localparam int QW = 32;

    typedef struct packed {
        logic signed [QW-1:0] val;
        logic                 sat;
    } quant_t;

    // x is interpreted as an in_w-bit signed value (upper bits ignored).
    // round=1: y = sat_bw((x + 2^(shift-1)) >>> shift), sum kept one bit wider.
    // round=0: y = x[shift+bw-1:shift], sign-extended from bw bits (wraps).
    function automatic quant_t quant(input logic signed [QW-1:0] x,
                                     input int in_w, input int bw,
                                     input int shift, input logic round);
        quant_t               q;
        logic signed [QW-1:0] xs;
        logic signed [QW-1:0] t;
        logic signed [QW:0]   s;
        logic signed [QW:0]   one;
        logic signed [QW:0]   hi;
        logic signed [QW:0]   lo;
        q   = '0;
        one = {{QW{1'b0}}, 1'b1};
        xs  = (x <<< (QW - in_w)) >>> (QW - in_w);
        if (round) begin
            s  = $signed({xs[QW-1], xs}) + (one <<< (shift - 1));
            s  = s >>> shift;
            hi = (one <<< (bw - 1)) - one;
            lo = -(one <<< (bw - 1));
            if (s > hi) begin
                q.val = hi[QW-1:0];
                q.sat = 1'b1;
            end else if (s < lo) begin
                q.val = lo[QW-1:0];
                q.sat = 1'b1;
            end else begin
                q.val = s[QW-1:0];
            end
        end else begin
            t     = xs >>> shift;
            t     = (t <<< (QW - bw)) >>> (QW - bw);
            q.val = t;
        end
        return q;
    endfunction

endpackage

// File: rtl/tile_bank_ram.sv
// One bank of the ping-pong tile buffer: simple dual-port synchronous RAM.
//   clk          : clock
//   we/waddr/wdata : write port, stored at the rising edge
//   re/raddr     : read port; rdata updates at the edge where re is high
//   rdata        : registered read data (1-cycle latency)
// No reset: contents are meaningless until written.
module tile_bank_ram #(
    parameter int ROWS = 32,
    parameter int DW   = 352,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_tile_pingpong.sv
// Ping-pong tile buffer between the forward 2-D FFT and the HAC array.
// Rows are quantised on the way in, stored into one of two banks, and whole
// tiles are streamed out through a 2-entry skid buffer with valid/ready.
//   clk, reset           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input row handshake
//   in_data              : N complex lanes, re at [2k*IN_W], im at [(2k+1)*IN_W]
//   out_valid/out_ready  : output row handshake
//   out_data             : same lane packing at width BW
//   out_row/out_last     : row index within tile / last row of tile
//   out_bank             : bank the row was read from
//   sat_clr/sat_flag     : sticky saturation flag and its synchronous clear
module fft_tile_pingpong
    import conv_pkg::*;
#(
    parameter int N     = 16,
    parameter int IN_W  = 16,
    parameter int BW    = 11,
    parameter int SHIFT = 5,
    parameter int ROWS  = 32,
    parameter int ROUND = 1,
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*2*IN_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*2*BW-1:0]   out_data,
    output logic [AW-1:0]       out_row,
    output logic                out_last,
    output logic                out_bank,
    input  logic                sat_clr,
    output logic                sat_flag
);

    localparam int            DW       = N*2*BW;
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    // ---------------- quantisation (combinational into RAM write port)
    logic [DW-1:0]  wdata;
    logic [2*N-1:0] sat_vec;

    for (genvar c = 0; c < 2*N; c++) begin : g_q
        quant_t q;
        logic   unused_hi;
        always_comb q = quant(QW'($signed(in_data[c*IN_W +: IN_W])),
                              IN_W, BW, SHIFT, ROUND != 0);
        assign wdata[c*BW +: BW] = q.val[BW-1:0];
        assign sat_vec[c]        = q.sat;
        assign unused_hi         = ^q.val[QW-1:BW];
    end

    // ---------------- bank state and pointers
    bank_state_e   bst [2];
    logic          wsel, rsel;
    logic [AW-1:0] waddr, raddr;
    logic          wr_en, rd_en, pop, rd_space;
    logic [1:0]    cnt, occ;

    // in-flight RAM read, tagged with where it belongs in the stream
    logic          rd_vld;
    logic [AW-1:0] rd_row;
    logic          rd_last, rd_bank;

    // second skid entry; the head entry is the out_* register set
    logic [DW-1:0] sk1_data;
    logic [AW-1:0] sk1_row;
    logic          sk1_last, sk1_bank;

    logic [1:0][DW-1:0] rdata;
    logic [DW-1:0]      push_data;

    assign in_ready  = (bst[wsel] == EMPTY) || (bst[wsel] == FILLING);
    assign wr_en     = in_valid && in_ready;
    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    // Reserve a skid slot for every read in flight so the RAM output
    // never has to be held; a pop this cycle frees a slot immediately.
    assign occ      = cnt + {1'b0, rd_vld};
    assign rd_space = (occ < 2'd2) || pop;
    assign rd_en    = ((bst[rsel] == FULL) || (bst[rsel] == DRAINING)) && rd_space;

    assign push_data = rdata[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tile_bank_ram #(.ROWS(ROWS), .DW(DW), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (wr_en && (wsel == 1'(b))),
            .waddr (waddr),
            .wdata (wdata),
            .re    (rd_en && (rsel == 1'(b))),
            .raddr (raddr),
            .rdata (rdata[b])
        );
    end

    // Bank FSMs. A bank can never be written and read in the same cycle
    // (write needs EMPTY/FILLING, read needs FULL/DRAINING), so the two
    // branches only ever collide across different banks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bst[0] <= EMPTY;
            bst[1] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_en && (wsel == 1'(b)))
                    bst[b] <= (waddr == LAST_ROW) ? FULL : FILLING;
                else if (rd_en && (rsel == 1'(b)))
                    bst[b] <= (raddr == LAST_ROW) ? EMPTY : DRAINING;
            end
        end
    end

    // Write pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wsel  <= 1'b0;
            waddr <= '0;
        end else if (wr_en) begin
            if (waddr == LAST_ROW) begin
                waddr <= '0;
                wsel  <= ~wsel;
            end else begin
                waddr <= waddr + 1'b1;
            end
        end
    end

    // Read pointer and in-flight tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsel    <= 1'b0;
            raddr   <= '0;
            rd_vld  <= 1'b0;
            rd_row  <= '0;
            rd_last <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_row  <= raddr;
                rd_last <= (raddr == LAST_ROW);
                rd_bank <= rsel;
                if (raddr == LAST_ROW) begin
                    raddr <= '0;
                    rsel  <= ~rsel;
                end else begin
                    raddr <= raddr + 1'b1;
                end
            end
        end
    end

    // 2-entry skid buffer; head drives the outputs directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 2'd0;
            out_data <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
            out_bank <= 1'b0;
            sk1_data <= '0;
            sk1_row  <= '0;
            sk1_last <= 1'b0;
            sk1_bank <= 1'b0;
        end else begin
            case ({rd_vld, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        out_data <= push_data;
                        out_row  <= rd_row;
                        out_last <= rd_last;
                        out_bank <= rd_bank;
                    end else begin
                        sk1_data <= push_data;
                        sk1_row  <= rd_row;
                        sk1_last <= rd_last;
                        sk1_bank <= rd_bank;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    out_data <= sk1_data;
                    out_row  <= sk1_row;
                    out_last <= sk1_last;
                    out_bank <= sk1_bank;
                    cnt      <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        out_data <= push_data;
                        out_row  <= rd_row;
                        out_last <= rd_last;
                        out_bank <= rd_bank;
                    end else begin
                        out_data <= sk1_data;
                        out_row  <= sk1_row;
                        out_last <= sk1_last;
                        out_bank <= sk1_bank;
                        sk1_data <= push_data;
                        sk1_row  <= rd_row;
                        sk1_last <= rd_last;
                        sk1_bank <= rd_bank;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky saturation flag; a saturating write wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  sat_flag <= 1'b0;
        else if (wr_en && |sat_vec)  sat_flag <= 1'b1;
        else if (sat_clr)            sat_flag <= 1'b0;
    end

endmodule

// File: tb/tb_fft_tile_pingpong.sv
module tb_fft_tile_pingpong;

    localparam int N = 2, IN_W = 16, BW = 11, SHIFT = 5, ROWS = 4, AW = 2;
    localparam int DI = N*2*IN_W, DO = N*2*BW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [DI-1:0] in_data = '0;
    logic [DO-1:0] out_data;
    logic [AW-1:0] out_row;
    logic          out_last, out_bank, sat_clr = 1'b0, sat_flag;

    // second instance with truncation
    logic          in_valid_t = 1'b0, in_ready_t, out_valid_t, out_ready_t = 1'b1;
    logic [DI-1:0] in_data_t = '0;
    logic [DO-1:0] out_data_t;
    logic [AW-1:0] out_row_t;
    logic          out_last_t, out_bank_t, sat_flag_t;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fft_tile_pingpong #(.N(N), .IN_W(IN_W), .BW(BW), .SHIFT(SHIFT), .ROWS(ROWS), .ROUND(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_last(out_last), .out_bank(out_bank), .sat_clr(sat_clr), .sat_flag(sat_flag));

    fft_tile_pingpong #(.N(N), .IN_W(IN_W), .BW(BW), .SHIFT(SHIFT), .ROWS(ROWS), .ROUND(0)) dut_t (
        .clk(clk), .reset(reset), .in_valid(in_valid_t), .in_ready(in_ready_t), .in_data(in_data_t),
        .out_valid(out_valid_t), .out_ready(out_ready_t), .out_data(out_data_t), .out_row(out_row_t),
        .out_last(out_last_t), .out_bank(out_bank_t), .sat_clr(1'b0), .sat_flag(sat_flag_t));

    function automatic logic [DI-1:0] rowi(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction
    function automatic logic [DI-1:0] repi(input int a);
        return rowi(a, a, a, a);
    endfunction
    function automatic logic [DO-1:0] rowo(input int a, input int b, input int c, input int d);
        return {11'(d), 11'(c), 11'(b), 11'(a)};
    endfunction
    function automatic logic [DO-1:0] repo(input int a);
        return rowo(a, a, a, a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 64'(obs), 64'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0; in_valid_t = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_row(input logic [DI-1:0] d);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 50) begin tick(); w++; end
        chk1("wr_accept", w < 50, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // waits (bounded) for a transfer, checks it, then steps past its edge
    task automatic chk_out(input string tag, input logic [DO-1:0] d, input int row,
                           input logic last, input logic bank, input int maxw);
        int w = 0;
        logic [63:0] obs, exp;
        while (!(out_valid && out_ready) && w < maxw) begin tick(); w++; end
        chk1({tag, "_vld"}, out_valid && out_ready, 1'b1);
        obs = '0; exp = '0;
        obs[DO+AW+1:0] = {out_data, out_row, out_last, out_bank};
        exp[DO+AW+1:0] = {d, 2'(row), last, bank};
        chk(tag, obs, exp);
        tick();
    endtask

    initial begin
        int acc, first_drop, w;

        // ---- reset values
        tick(); tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out", 64'({out_data, out_row, out_last, out_bank}), 64'd0);
        chk1("rst_sat", sat_flag, 1'b0);
        reset = 1'b1;
        tick();

        // ---- 1: one tile, out_ready=1, latency and ordering
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) write_row(repi(32*(r+1)));
        write_row(repi(128));
        chk1("t1_lat0", out_valid, 1'b0);
        tick();
        chk1("t1_lat1", out_valid, 1'b0);
        tick();
        chk1("t1_lat2", out_valid, 1'b1);
        for (int r = 0; r < 4; r++) chk_out("t1_row", repo(r+1), r, r == 3, 1'b0, 0);
        chk1("t1_idle", out_valid, 1'b0);

        // ---- 2: backpressure fills both banks
        do_reset();
        out_ready = 1'b0; acc = 0; first_drop = -1;
        in_valid = 1'b1; in_data = repi(32);
        for (int c = 0; c < 14; c++) begin
            if (in_ready) begin
                tick(); acc++; in_data = repi(32*(acc+1));
            end else begin
                if (first_drop < 0) first_drop = acc;
                tick();
            end
        end
        in_valid = 1'b0;
        chk("t2_acc", 64'(acc), 64'd8);
        chk("t2_drop_at", 64'(first_drop), 64'd8);
        chk1("t2_inrdy_lo", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++)
            chk_out("t2_row", repo(k), (k-1)%4, ((k-1)%4) == 3, 1'((k-1)/4), (k == 1) ? 2 : 0);
        chk1("t2_inrdy_hi", in_ready, 1'b1);

        // ---- 3: three tiles, out_ready toggling
        fork
            begin
                for (int t = 0; t < 3; t++)
                    for (int r = 0; r < 4; r++) write_row(repi(32*(9+4*t+r)));
            end
            begin
                int got = 0;
                logic prev_stall = 1'b0;
                logic [DO-1:0] prev_d = '0;
                for (int c = 0; c < 300 && got < 12; c++) begin
                    out_ready = (c % 2) == 0;
                    if (prev_stall) begin
                        chk1("t3_hold_vld", out_valid, 1'b1);
                        chk("t3_hold_dat", 64'(out_data), 64'(prev_d));
                    end
                    if (out_valid && out_ready) begin
                        chk("t3_row", 64'({out_data, out_row, out_last, out_bank}),
                            64'({repo(9+got), 2'(got%4), got%4 == 3, 1'((got/4)%2)}));
                        got++;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_d = out_data;
                    tick();
                end
                chk("t3_count", 64'(got), 64'd12);
            end
        join
        out_ready = 1'b1;

        // ---- 4: quantisation and sat_flag
        do_reset();
        out_ready = 1'b1;
        write_row(rowi(32'h7FFF, 16, -16, -17));
        chk1("q_sat_set", sat_flag, 1'b1);
        sat_clr = 1'b1;
        write_row(repi(48));
        sat_clr = 1'b0;
        chk1("q_sat_clr", sat_flag, 1'b0);
        write_row(rowi(-32768, 0, 0, 0));
        chk1("q_min_nosat", sat_flag, 1'b0);
        sat_clr = 1'b1;
        write_row(repi(32'h7FFF));
        sat_clr = 1'b0;
        chk1("q_set_prio", sat_flag, 1'b1);
        chk_out("q_row0", rowo(1023, 1, 0, -1), 0, 1'b0, 1'b0, 3);
        chk_out("q_row1", repo(2), 1, 1'b0, 1'b0, 0);
        chk_out("q_row2", rowo(-1024, 0, 0, 0), 2, 1'b0, 1'b0, 0);
        chk_out("q_row3", repo(1023), 3, 1'b1, 1'b0, 0);
        sat_clr = 1'b1; tick(); sat_clr = 1'b0;
        chk1("q_sat_clr2", sat_flag, 1'b0);

        // truncating instance
        in_valid_t = 1'b1;
        in_data_t = repi(16);                          tick();
        in_data_t = rowi(32'h7FFF, 48, -17, -16);      tick();
        in_data_t = repi(32);                          tick();
        in_data_t = repi(0);                           tick();
        in_valid_t = 1'b0;
        w = 0;
        while (!out_valid_t && w < 10) begin tick(); w++; end
        chk1("tr_vld", out_valid_t, 1'b1);
        chk("tr_row0", 64'(out_data_t), 64'(repo(0)));                 tick();
        chk("tr_row1", 64'(out_data_t), 64'(rowo(1023, 1, -1, -1)));   tick();
        chk("tr_row2", 64'(out_data_t), 64'(repo(1)));                 tick();
        chk("tr_row3", 64'({out_data_t, out_row_t, out_last_t}), 64'({repo(0), 2'd3, 1'b1}));
        chk1("tr_nosat", sat_flag_t, 1'b0);

        // ---- 5: reset mid-drain
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) write_row(repi(32*k));
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++)
            chk_out("r_row", repo(k), (k-1)%4, ((k-1)%4) == 3, 1'((k-1)/4), 2);
        reset = 1'b0;
        #1;
        chk1("r_in_ready", in_ready, 1'b1);
        chk1("r_out_valid", out_valid, 1'b0);
        chk("r_out", 64'({out_data, out_row, out_last, out_bank}), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) write_row(repi(32*(k+4)));
        chk_out("r_fresh0", repo(5), 0, 1'b0, 1'b0, 5);

        // ---- 6: bank1 fill ends on the edge of bank0's last drain read
        do_reset();
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    in_valid = 1'b1;
                    in_data = repi(32*(k+1));
                    chk1("s_inrdy", in_ready, 1'b1);
                    tick();
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 12; k++)
                    chk_out("s_row", repo(k+1), k%4, (k%4) == 3, 1'((k/4)%2), (k == 0) ? 10 : 0);
            end
        join
        chk1("s_idle", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_tile_pingpong.md
# fft_tile_pingpong

Parametrised ping-pong tile buffer between the forward 2-D FFT and the HAC array in the FFT-convolution AFU. It quantises each FFT output row (N complex lanes) to BW bits with selectable truncate or round/saturate behaviour. It stores rows into one of two banks, each holding one tile of ROWS rows. It streams completed tiles to the HAC with full valid/ready backpressure, so the FFT can fill one bank while the other drains.

## Interface
- N, 16: complex lanes per row
- IN_W, 16: signed width of each input real/imag component
- BW, 11: signed width of each stored/output component
- SHIFT, 5: right shift applied before narrowing; 1 ≤ SHIFT ≤ IN_W-BW
- ROWS, 32: rows per tile (bank depth); power of two not required
- ROUND, 1: 0 = truncate (take bits [SHIFT+BW-1:SHIFT], wraps), 1 = round-half-up then saturate
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  buffer can accept a row this cycle
- in_data  in  N*2*IN_W  lane k: real at [2k*IN_W +: IN_W], imag at [(2k+1)*IN_W +: IN_W]
- out_valid  out  1  output row valid
- out_ready  in  1  HAC accepts output row
- out_data  out  N*2*BW  same lane packing as in_data, at width BW
- out_row  out  clog2(ROWS)  row index within tile of out_data
- out_last  out  1  out_data is row ROWS-1 of its tile
- out_bank  out  1  bank that out_data came from
- sat_clr  in  1  synchronous clear of sat_flag
- sat_flag  out  1  sticky: a component saturated (ROUND=1 only; constant 0 when ROUND=0)

## Operation
- Each bank has a state: EMPTY → FILLING → FULL → DRAINING → EMPTY.
- Write side: wsel (reset 0) selects the bank; waddr (reset 0).
  - in_ready = state[wsel] ∈ {EMPTY, FILLING}.
  - On in_valid&&in_ready: write the quantised row at waddr; bank goes to FILLING.
  - At waddr==ROWS-1 the bank goes to FULL, waddr→0 and wsel toggles.
  - in_valid without in_ready has no effect; the producer holds its data.
- Read side: rsel (reset 0) selects the bank; raddr (reset 0).
  - When state[rsel]==FULL the bank goes to DRAINING and reads are issued from the synchronous RAM (1-cycle read latency) into a 2-entry output skid buffer.
  - A read is issued only when the skid buffer has space that cycle, counting an entry popped the same cycle.
  - After the read of row ROWS-1 is issued: raddr→0, the bank goes to EMPTY and rsel toggles. The skid buffer still holds the pending rows.
- Tiles leave in the order they were filled, and rows leave in ascending order. No row is lost or duplicated under any out_ready pattern.
- Quantisation, per component x:
  - ROUND=1: y = sat_BW((x + 2^(SHIFT-1)) >>> SHIFT), with the addition done at IN_W+1 bits. Saturation limits are ±(2^(BW-1)) / 2^(BW-1)-1. Any saturating component sets sat_flag.
  - ROUND=0: y = x[SHIFT+BW-1:SHIFT].
- sat_flag: set has priority over sat_clr in the same cycle.

## Timing
- Quantisation is combinational into the RAM write port. The row is stored at the accepting edge.
- The bank becomes FULL at the edge that writes row ROWS-1. The first read is issued on the next edge. out_valid rises 2 edges after the FULL edge.
- With out_ready held 1 there are no bubbles: one row per cycle for ROWS cycles. Consecutive tiles are back-to-back if the next bank is already FULL.
- Simultaneous events are legal and independent:
  - One bank finishing its fill while the other finishes its drain.
  - A write and a read on different banks in the same cycle.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_row=0, out_last=0, out_bank=0, sat_flag=0. Both banks EMPTY, all pointers 0, skid buffer empty. RAM contents are don't-care.
- Reset asserted mid-fill or mid-drain discards all tile data. Output starts again from the reset values.

## Structure
- The shared package conv_pkg holds:
  - the bank_state_e enum (EMPTY, FILLING, FULL, DRAINING);
  - the function quant(x, IN_W, BW, SHIFT, ROUND) returning value and saturation bit.
- Sub-module tile_bank_ram: simple dual-port synchronous RAM (ROWS × N*2*BW), one write port and one read port, no reset. It is instantiated twice.
- The skid buffer and bank FSMs live in the top module.

## Test plan
- N=2, ROWS=4, ROUND=1, out_ready=1: write rows r=0..3 with every component = 32·(r+1) → rows out with components 1,2,3,4; out_row 0..3; out_last only on row 3; out_bank=0.
- out_ready=0, 12 rows offered back-to-back → in_ready drops after the 8th accepted row. Raise out_ready → 8 rows out (banks 0 then 1), then in_ready returns to 1.
- 3 tiles streaming with out_ready toggling 1,0,1,0 → 12 rows out in order, no duplicates or gaps; out_valid held stable while stalled.
- ROUND=1, SHIFT=5, BW=11: inputs 0x7FFF→0x3FF (sat_flag=1), 16→1, -16→0, -17→-1, 48→2. Pulse sat_clr → sat_flag=0. ROUND=0: input 16→0.
- Reset asserted after 2 rows of tile 2 are drained → all outputs reach reset values immediately. A fresh tile afterwards comes out from bank 0, row 0.
- Last fill of bank 1 on the same edge as the last drain read of bank 0 → bank 1 drains next cycle, and in_ready=1 for bank 0 the cycle after.
